// File: rtl/join_result_packer.sv
// Packs joined probe results into TUPLES_PER_BEAT-lane beats and flushes a keep-masked tail on end-of-stream.
// Optional build macro JOIN_STATS_EN adds probe_count and stall_count outputs.
module join_result_packer #(
  parameter int TUPLES_PER_BEAT = 4,
  parameter int TUPLE_WIDTH     = 128,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [TUPLE_WIDTH-1:0]                 in_data,
  input  logic                                   in_was_joined,
  input  logic [63:0]                            in_serialnum,
  input  logic                                   in_last_processed,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [TUPLES_PER_BEAT*TUPLE_WIDTH-1:0] out_data,
  output logic [TUPLES_PER_BEAT-1:0]             out_keep,
  output logic [63:0]                            out_first_serial,
  output logic                                   out_last,
  output logic [COUNT_WIDTH-1:0]                 match_count,
  output logic                                   done
`ifdef JOIN_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0]                 probe_count,
  output logic [COUNT_WIDTH-1:0]                 stall_count
`endif
);

  localparam int LW = $clog2(TUPLES_PER_BEAT);
  localparam int FW = LW + 1;
  localparam int DW = TUPLES_PER_BEAT * TUPLE_WIDTH;
  localparam logic [FW-1:0] FULL = FW'(TUPLES_PER_BEAT);

  typedef enum logic [1:0] {COLLECT, FLUSH, LAST, DONE} state_t;

  state_t                     state_q;
  logic [TUPLE_WIDTH-1:0]     lanes_q [TUPLES_PER_BEAT];
  logic [FW-1:0]              fill_q;
  logic [63:0]                serial_q;
  logic                       out_valid_q;
  logic [DW-1:0]              out_data_q;
  logic [TUPLES_PER_BEAT-1:0] out_keep_q;
  logic [63:0]                out_first_serial_q;
  logic                       out_last_q;
  logic [COUNT_WIDTH-1:0]     match_count_q;
  logic                       done_q;

  logic                       slot_free;
  logic                       buf_full;
  logic                       accept;
  logic                       emit_full;
  logic                       emit_last;
  logic [DW-1:0]              packed_data;
  logic [TUPLES_PER_BEAT-1:0] packed_keep;

  assign slot_free = !out_valid_q || out_ready;
  assign buf_full  = (fill_q == FULL);
  assign in_ready  = (state_q == COLLECT) && !buf_full;
  assign accept    = in_valid && in_ready;
  assign emit_full = ((state_q == COLLECT) || (state_q == FLUSH)) && buf_full && slot_free;
  assign emit_last = (state_q == FLUSH) && !buf_full && slot_free;

  // Lanes at or beyond fill are forced to zero so stale pairs never leak into a tail beat.
  genvar gi;
  generate
    for (gi = 0; gi < TUPLES_PER_BEAT; gi++) begin : g_lane
      assign packed_keep[gi] = (FW'(gi) < fill_q);
      assign packed_data[gi*TUPLE_WIDTH +: TUPLE_WIDTH] = packed_keep[gi] ? lanes_q[gi] : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= COLLECT;
      fill_q             <= '0;
      serial_q           <= '0;
      out_valid_q        <= 1'b0;
      out_data_q         <= '0;
      out_keep_q         <= '0;
      out_first_serial_q <= '0;
      out_last_q         <= 1'b0;
      match_count_q      <= '0;
      done_q             <= 1'b0;
      for (int i = 0; i < TUPLES_PER_BEAT; i++) lanes_q[i] <= '0;
    end else begin
      // Accept and emit are mutually exclusive: emit needs a full buffer or FLUSH, both of which drop in_ready.
      if (accept && in_was_joined) begin
        lanes_q[fill_q[LW-1:0]] <= in_data;
        fill_q                  <= fill_q + FW'(1);
        match_count_q           <= match_count_q + COUNT_WIDTH'(1);
        if (fill_q == '0) serial_q <= in_serialnum;
      end

      if (emit_full || emit_last) begin
        out_valid_q        <= 1'b1;
        out_data_q         <= packed_data;
        out_keep_q         <= packed_keep;
        out_first_serial_q <= (fill_q == '0) ? 64'd0 : serial_q;
        out_last_q         <= emit_last;
        fill_q             <= '0;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        COLLECT: if (in_ready && in_last_processed) state_q <= FLUSH;
        FLUSH:   if (emit_last) state_q <= LAST;
        LAST: begin
          if (out_valid_q && out_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= DONE;
      endcase
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_keep         = out_keep_q;
  assign out_first_serial = out_first_serial_q;
  assign out_last         = out_last_q;
  assign match_count      = match_count_q;
  assign done             = done_q;

`ifdef JOIN_STATS_EN
  logic [COUNT_WIDTH-1:0] probe_count_q;
  logic [COUNT_WIDTH-1:0] stall_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      probe_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (accept) probe_count_q <= probe_count_q + COUNT_WIDTH'(1);
      if (out_valid_q && !out_ready && !(&stall_count_q))
        stall_count_q <= stall_count_q + COUNT_WIDTH'(1);
    end
  end

  assign probe_count = probe_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
